// File: rtl/copy_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : copy_cmd_queue
// Description : Descriptor FIFO that issues queued copy requests to the copier
//               one at a time (start pulse, wait for finished, retire).
// Revision    : 1.0 - initial release
// ============================================================================
module copy_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_src,
  input  logic [AW-1:0]            req_dst,
  input  logic [AW-1:0]            req_size,
  output logic [AW-1:0]            cp_src_addr,
  output logic [AW-1:0]            cp_dst_addr,
  output logic [AW-1:0]            cp_copy_size,
  output logic                     cp_start,
  input  logic                     cp_finished,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     busy,
  output logic                     done_pulse,
  output logic [7:0]               done_count
);

  localparam int c_PW = $clog2(DEPTH);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ISSUE  = 2'd1;
  localparam logic [1:0] c_WAIT   = 2'd2;
  localparam logic [1:0] c_RETIRE = 2'd3;

  localparam logic [c_PW:0]   c_FULL    = DEPTH[c_PW:0];
  localparam logic [c_PW:0]   c_CNT_ONE = {{c_PW{1'b0}}, 1'b1};
  localparam logic [c_PW-1:0] c_PTR_ONE = {{(c_PW-1){1'b0}}, 1'b1};

  logic [AW-1:0]   r_mem_src  [DEPTH];
  logic [AW-1:0]   r_mem_dst  [DEPTH];
  logic [AW-1:0]   r_mem_size [DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW:0]   r_count;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [AW-1:0]   r_cp_src;
  logic [AW-1:0]   r_cp_dst;
  logic [AW-1:0]   r_cp_size;
  logic [7:0]      r_done_count;
  logic            w_push;
  logic            w_pop;

  // Ready comes straight from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign req_ready = (r_count != c_FULL);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == c_IDLE) && (r_count != '0);

  assign pending      = r_count;
  assign cp_src_addr  = r_cp_src;
  assign cp_dst_addr  = r_cp_dst;
  assign cp_copy_size = r_cp_size;
  assign done_count   = r_done_count;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_src[r_wr_ptr]  <= req_src;
      r_mem_dst[r_wr_ptr]  <= req_dst;
      r_mem_size[r_wr_ptr] <= req_size;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Copier operands stay at the last issued descriptor until the next pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cp_src  <= '0;
      r_cp_dst  <= '0;
      r_cp_size <= '0;
    end else if (w_pop) begin
      r_cp_src  <= r_mem_src[r_rd_ptr];
      r_cp_dst  <= r_mem_dst[r_rd_ptr];
      r_cp_size <= r_mem_size[r_rd_ptr];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= c_IDLE;
      r_done_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_RETIRE) r_done_count <= r_done_count + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        // Zero-length descriptors retire without ever starting the copier.
        if (w_pop) w_state_nxt = (r_mem_size[r_rd_ptr] != '0) ? c_ISSUE : c_RETIRE;
      end
      c_ISSUE:  w_state_nxt = c_WAIT;
      c_WAIT:   if (cp_finished) w_state_nxt = c_RETIRE;
      c_RETIRE: w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    cp_start   = 1'b0;
    done_pulse = 1'b0;
    busy       = 1'b1;
    case (r_state)
      c_IDLE:   busy       = 1'b0;
      c_ISSUE:  cp_start   = 1'b1;
      c_RETIRE: done_pulse = 1'b1;
      default:  ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_copy_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_copy_cmd_queue
// Description : Self-checking bench for copy_cmd_queue against a queue-based
//               descriptor model and a simple copier responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_copy_cmd_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  typedef struct packed {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] size;
  } desc_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_src = '0;
  logic [AW-1:0] req_dst = '0;
  logic [AW-1:0] req_size = '0;
  logic [AW-1:0] cp_src_addr;
  logic [AW-1:0] cp_dst_addr;
  logic [AW-1:0] cp_copy_size;
  logic          cp_start;
  logic          cp_finished = 1'b0;
  logic [$clog2(DEPTH):0] pending;
  logic          busy;
  logic          done_pulse;
  logic [7:0]    done_count;

  int    n_cmp = 0;
  int    n_err = 0;
  int    exp_done = 0;
  int    fin_timer = 0;
  bit    started = 1'b0;
  bit    auto_cp = 1'b0;
  bit    last_acc = 1'b0;
  desc_t exp_q[$];

  copy_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) u_dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_src      (req_src),
    .req_dst      (req_dst),
    .req_size     (req_size),
    .cp_src_addr  (cp_src_addr),
    .cp_dst_addr  (cp_dst_addr),
    .cp_copy_size (cp_copy_size),
    .cp_start     (cp_start),
    .cp_finished  (cp_finished),
    .pending      (pending),
    .busy         (busy),
    .done_pulse   (done_pulse),
    .done_count   (done_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_cmp++;
    if (obs !== expd) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expd, $time);
    end
  endtask

  // Model: exp_q holds every accepted descriptor not yet retired; its head is
  // the one in flight (or next to go). Retirement count is tracked separately.
  task automatic monitor();
    check_val("done_count", done_count, exp_done[7:0]);
    check_val("occupancy", 32'(pending) + 32'(busy), exp_q.size());
    check_val("req_ready", req_ready, (exp_q.size() - int'(busy)) < DEPTH);
    if (cp_start) begin
      check_val("start_has_desc", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check_val("start_once", started, 0);
        check_val("start_size_nz", exp_q[0].size != 8'd0, 1);
        started = 1'b1;
      end
    end
    if (started && exp_q.size() != 0) begin
      check_val("cp_src", cp_src_addr, exp_q[0].src);
      check_val("cp_dst", cp_dst_addr, exp_q[0].dst);
      check_val("cp_size", cp_copy_size, exp_q[0].size);
    end
    if (done_pulse) begin
      check_val("done_has_desc", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check_val("retire_started", started, exp_q[0].size != 8'd0);
        void'(exp_q.pop_front());
        started = 1'b0;
        exp_done++;
      end
    end
  endtask

  task automatic tick();
    bit    acc;
    desc_t d;
    acc    = req_valid && req_ready;
    d.src  = req_src;
    d.dst  = req_dst;
    d.size = req_size;
    @(posedge CLK); #1;
    last_acc = acc;
    if (acc) exp_q.push_back(d);
    monitor();
    cp_finished = 1'b0;
    if (auto_cp) begin
      if (fin_timer > 0) begin
        fin_timer--;
        if (fin_timer == 0) cp_finished = 1'b1;
      end
      if (cp_start) fin_timer = $urandom_range(1, 4);
    end
  endtask

  task automatic push(input logic [7:0] s, input logic [7:0] d, input logic [7:0] z);
    req_src   = s;
    req_dst   = d;
    req_size  = z;
    req_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (last_acc) break;
    end
    check_val("push_accepted", last_acc, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    auto_cp = 1'b1;
    if (started && fin_timer == 0) fin_timer = 2;
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    check_val("drain_empty", (exp_q.size() == 0) && !busy, 1);
    auto_cp = 1'b0;
  endtask

  task automatic apply_reset();
    #2;
    RST = 1'b1;
    #1;
    check_val("rst_pending", pending, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", req_ready, 1);
    check_val("rst_start", cp_start, 0);
    check_val("rst_done_pulse", done_pulse, 0);
    check_val("rst_done_count", done_count, 0);
    check_val("rst_cp_fields", {cp_src_addr, cp_dst_addr, cp_copy_size}, 0);
    exp_q.delete();
    started     = 1'b0;
    exp_done    = 0;
    fin_timer   = 0;
    cp_finished = 1'b0;
    req_valid   = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // Single descriptor with exact latency
    push(8'h00, 8'hF0, 8'h08);
    check_val("t1_no_start_yet", cp_start, 0);
    tick();
    check_val("t1_start", cp_start, 1);
    check_val("t1_fields", {cp_src_addr, cp_dst_addr, cp_copy_size}, 24'h00F008);
    repeat (3) tick();
    check_val("t1_start_pulse", cp_start, 0);
    check_val("t1_busy_wait", busy, 1);
    cp_finished = 1'b1;
    tick();
    check_val("t1_done_pulse", done_pulse, 1);
    tick();
    check_val("t1_done_pulse_end", done_pulse, 0);
    check_val("t1_done_count", done_count, 1);
    check_val("t1_idle", busy, 0);

    // Fill with copier stalled
    for (int i = 0; i < 4; i++) push(8'($urandom), 8'($urandom), 8'($urandom_range(1, 255)));
    check_val("t2_pending3", pending, 3);
    check_val("t2_busy", busy, 1);
    push(8'h55, 8'hAA, 8'h07);
    check_val("t2_pending4", pending, 4);
    check_val("t2_full", req_ready, 0);
    req_src = 8'h66; req_dst = 8'h77; req_size = 8'h09; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t2_held", last_acc, 0);
      check_val("t2_pending_hold", pending, 4);
    end
    cp_finished = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (last_acc) break;
    end
    check_val("t2_sixth_accepted", last_acc, 1);
    req_valid = 1'b0;
    drain();
    check_val("t2_done_count", done_count, 7);

    // Zero-size descriptor never starts the copier
    push(8'h10, 8'h20, 8'h00);
    check_val("t3_no_done_yet", done_pulse, 0);
    tick();
    check_val("t3_done_pulse", done_pulse, 1);
    check_val("t3_no_start", cp_start, 0);
    tick();
    check_val("t3_done_count", done_count, 8);

    // Concurrent push and pop
    push(8'h01, 8'h02, 8'h03);
    tick();
    push(8'h04, 8'h05, 8'h06);
    check_val("t4_pending1", pending, 1);
    cp_finished = 1'b1;
    tick();
    tick();
    check_val("t4_idle_before", busy, 0);
    push(8'h07, 8'h08, 8'h09);
    check_val("t4_pending_same", pending, 1);
    check_val("t4_busy", busy, 1);
    drain();
    cp_finished = 1'b1;
    tick();
    check_val("t4_stray_done", done_pulse, 0);
    check_val("t4_stray_busy", busy, 0);
    tick();
    check_val("t4_stray_done2", done_pulse, 0);

    // Reset in WAIT with two queued
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i), 8'(8'h40 + i), 8'(i + 1));
    check_val("t5_pending2", pending, 2);
    check_val("t5_busy", busy, 1);
    apply_reset();
    push(8'h33, 8'h44, 8'h05);
    tick();
    check_val("t5_restart", cp_start, 1);
    drain();
    check_val("t5_done_count", done_count, 1);

    // Wrap of pointers and done_count
    apply_reset();
    auto_cp = 1'b1;
    for (int i = 0; i < 260; i++) push(8'(i), 8'(i + 7), 8'h00);
    drain();
    check_val("t6_done_count_wrap", done_count, 4);

    // Randomized traffic
    auto_cp = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_src   = 8'($urandom);
      req_dst   = 8'($urandom);
      req_size  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      tick();
    end
    req_valid = 1'b0;
    drain();
    check_val("rand_final_done", done_count, exp_done[7:0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
